dmem_ctrl: RTL and testbench

//  Data-memory controller directly downstream of the MEM stage.
//  - Consumes MEM's combinational request: dm_re, dm_we, dm_addr, dm_in.
//  - Returns dm_out, plus dm_stall, which freezes the pipeline while an access is in flight.
//  - Models a word-addressed 16-bit SRAM with a fixed, parameterised wait-state count.
//  - Serves LW/SW data accesses and CALL/RET stack push/pop.

---
 rtl/dmem_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_ctrl : data-memory controller sitting directly behind the MEM stage.
//
// Models a word-addressed 16-bit SRAM with a fixed number of wait states and
// freezes the pipeline (dm_stall) while an access is in flight. It serves
// LW/SW data accesses and CALL/RET stack push/pop traffic alike.
//
// Parameters
//   ADDR_W       word-address bits used (array depth 2**ADDR_W); upper
//                dm_addr bits are ignored, so addresses alias modulo depth
//   WAIT_CYCLES  BUSY cycles per access (0..15)
//
// Ports
//   clk       in   1   rising-edge clock
//   rst_n     in   1   asynchronous reset, active low
//   dm_re     in   1   read request (level, held while dm_stall=1)
//   dm_we     in   1   write request (level); wins over dm_re
//   dm_addr   in   16  word address
//   dm_in     in   16  write data
//   dm_out    out  16  registered read data, holds last read value
//   dm_stall  out  1   request not yet complete, hold the pipeline
//   dm_err    out  1   one-cycle pulse after capturing a request with
//                      dm_re and dm_we both high
//
// Optional build macro
//   DMEM_WBUF_EN  adds a one-entry posted write buffer: an IDLE write with
//                 an empty buffer completes without stalling and drains to
//                 the array WAIT_CYCLES+1 cycles later. Any request while the
//                 buffer is occupied stalls until the drain commits.
// -----------------------------------------------------------------------------
module dmem_ctrl #(
  parameter int ADDR_W      = 12,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dm_re,
  input  logic        dm_we,
  input  logic [15:0] dm_addr,
  input  logic [15:0] dm_in,
  output logic [15:0] dm_out,
  output logic        dm_stall,
  output logic        dm_err
);

  localparam int DATA_W = 16;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam logic [3:0] CNT_INIT  = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
  localparam logic [3:0] DRAIN_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              req;
  logic [ADDR_W-1:0] req_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic              start;
  logic              rd_load;
  logic [3:0]        cnt;

  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_data;
  logic              cap_wr;

  logic [15-ADDR_W:0] unused_addr_hi;

  assign req            = dm_re | dm_we;
  assign req_addr       = dm_addr[ADDR_W-1:0];
  assign unused_addr_hi = dm_addr[15:ADDR_W];

`ifdef DMEM_WBUF_EN
  logic              wb_vld;
  logic [3:0]        wb_cnt;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              post;
  logic              drain;

  // Writes never enter the FSM in this build: they are posted to the buffer.
  // Anything arriving while the buffer is occupied waits in IDLE (stalled).
  assign post  = (state == S_IDLE) & dm_we & ~wb_vld;
  assign start = (state == S_IDLE) & dm_re & ~dm_we & ~wb_vld;
  assign drain = wb_vld & (wb_cnt == 4'd0);
`else
  assign start = (state == S_IDLE) & req;
`endif

  // A zero-wait read loads dm_out on the IDLE->DONE edge, before capture.
  assign rd_addr = (state == S_IDLE) ? req_addr : cap_addr;

  assign rd_load = ((state == S_BUSY) & req & (cnt == 4'd0) & ~cap_wr) |
                   (start & (WAIT_CYCLES == 0) & ~dm_we);

  // ---- FSM state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---- FSM next-state logic ----
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = (WAIT_CYCLES == 0) ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        if (!req) begin
          state_nxt = S_IDLE;
        end else if (cnt == 4'd0) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // ---- FSM outputs ----
  always_comb begin
`ifdef DMEM_WBUF_EN
    dm_stall = req & (state != S_DONE) & ~post;
`else
    dm_stall = req & (state != S_DONE);
`endif
  end

  // ---- wait-state counter ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 4'd0;
    end else if (start) begin
      cnt <= CNT_INIT;
    end else if ((state == S_BUSY) && req && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  // ---- request capture (data path, no reset) ----
  always_ff @(posedge clk) begin
    if (start) begin
      cap_addr <= req_addr;
      cap_data <= dm_in;
      cap_wr   <= dm_we;
    end
  end

  // ---- read data and error pulse ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dm_out <= '0;
      dm_err <= 1'b0;
    end else begin
`ifdef DMEM_WBUF_EN
      dm_err <= (start | post) & dm_re & dm_we;
`else
      dm_err <= start & dm_re & dm_we;
`endif
      if (rd_load) begin
        dm_out <= mem[rd_addr];
      end
    end
  end

`ifdef DMEM_WBUF_EN
  // ---- posted write buffer ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_vld <= 1'b0;
      wb_cnt <= 4'd0;
    end else if (post) begin
      wb_vld <= 1'b1;
      wb_cnt <= DRAIN_INIT;
    end else if (drain) begin
      wb_vld <= 1'b0;
    end else if (wb_vld) begin
      wb_cnt <= wb_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (post) begin
      wb_addr <= req_addr;
      wb_data <= dm_in;
    end
  end
`endif

  // ---- SRAM array ----
  // Not cleared by reset; rst_n gating keeps a reset edge from committing.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if ((state == S_DONE) && cap_wr) begin
        mem[cap_addr] <= cap_data;
      end
`ifdef DMEM_WBUF_EN
      if (drain) begin
        mem[wb_addr] <= wb_data;
      end
`endif
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_ctrl : directed self-checking bench for dmem_ctrl with default
// parameters (ADDR_W=12, WAIT_CYCLES=2). Inputs change 1 ns after the rising
// edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_dmem_ctrl;

  logic        clk;
  logic        rst_n;
  logic        dm_re;
  logic        dm_we;
  logic [15:0] dm_addr;
  logic [15:0] dm_in;
  logic [15:0] dm_out;
  logic        dm_stall;
  logic        dm_err;

  int n_cmp = 0;
  int n_bad = 0;

  dmem_ctrl #(
    .ADDR_W      (12),
    .WAIT_CYCLES (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .dm_re    (dm_re),
    .dm_we    (dm_we),
    .dm_addr  (dm_addr),
    .dm_in    (dm_in),
    .dm_out   (dm_out),
    .dm_stall (dm_stall),
    .dm_err   (dm_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dm_re = 1'b0;
    dm_we = 1'b0;
    next_cycle();
  endtask

  // One full access with WAIT_CYCLES=2: three stall cycles then DONE.
  // Address and data are scrambled after capture to show they are ignored.
  task automatic do_access(input string tag, input logic re, input logic we,
                           input logic [15:0] addr, input logic [15:0] data,
                           input logic chk_rd, input logic [15:0] exp_rd);
    dm_re   = re;
    dm_we   = we;
    dm_addr = addr;
    dm_in   = data;
    @(negedge clk);
    check({tag, "_stall0"}, {15'd0, dm_stall}, 16'd1);
    next_cycle();
    dm_addr = ~addr;
    dm_in   = ~data;
    @(negedge clk);
    check({tag, "_stall1"}, {15'd0, dm_stall}, 16'd1);
    check({tag, "_err1"}, {15'd0, dm_err}, {15'd0, re & we});
    next_cycle();
    @(negedge clk);
    check({tag, "_stall2"}, {15'd0, dm_stall}, 16'd1);
    check({tag, "_err2"}, {15'd0, dm_err}, 16'd0);
    next_cycle();
    @(negedge clk);
    check({tag, "_done"}, {15'd0, dm_stall}, 16'd0);
    if (chk_rd) begin
      check({tag, "_data"}, dm_out, exp_rd);
    end
    next_cycle();
  endtask

  initial begin
    rst_n   = 1'b0;
    dm_re   = 1'b0;
    dm_we   = 1'b0;
    dm_addr = 16'h0000;
    dm_in   = 16'h0000;
    repeat (2) next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_out", dm_out, 16'h0000);
    check("rst_err", {15'd0, dm_err}, 16'd0);
    check("idle_stall", {15'd0, dm_stall}, 16'd0);
    next_cycle();

    // Seed 0x0003 and make dm_out non-zero.
    do_access("sw3", 1'b0, 1'b1, 16'h0003, 16'h3333, 1'b0, 16'h0);
    idle();
    do_access("lw3", 1'b1, 1'b0, 16'h0003, 16'h0000, 1'b1, 16'h3333);
    idle();

    // Reset in the middle of a write, then hold requests during reset.
    dm_we   = 1'b1;
    dm_addr = 16'h0003;
    dm_in   = 16'hDEAD;
    next_cycle();
    next_cycle();
    rst_n   = 1'b0;
    dm_re   = 1'b1;
    dm_in   = 16'hFFFF;
    @(negedge clk);
    check("rstmid_out", dm_out, 16'h0000);
    check("rstmid_err", {15'd0, dm_err}, 16'd0);
    check("rstmid_stall", {15'd0, dm_stall}, 16'd1);
    next_cycle();
    dm_we = 1'b0;
    @(negedge clk);
    check("rstre_stall", {15'd0, dm_stall}, 16'd1);
    check("rstre_out", dm_out, 16'h0000);
    next_cycle();
    rst_n = 1'b1;
    dm_re = 1'b0;
    next_cycle();
    do_access("lw3_post_rst", 1'b1, 1'b0, 16'h0003, 16'h0000, 1'b1, 16'h3333);
    idle();

    // SW then LW at 0x0010.
    do_access("sw10", 1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0);
    idle();
    do_access("lw10", 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 16'hBEEF);
    idle();

    // Aborted read and aborted write at 0x0020.
    do_access("sw20", 1'b0, 1'b1, 16'h0020, 16'h2020, 1'b0, 16'h0);
    idle();
    dm_re   = 1'b1;
    dm_addr = 16'h0020;
    next_cycle();
    @(negedge clk);
    check("abrd_busy1", {15'd0, dm_stall}, 16'd1);
    next_cycle();
    dm_re = 1'b0;
    @(negedge clk);
    check("abrd_stall", {15'd0, dm_stall}, 16'd0);
    next_cycle();
    @(negedge clk);
    check("abrd_out", dm_out, 16'hBEEF);
    next_cycle();

    dm_we   = 1'b1;
    dm_addr = 16'h0020;
    dm_in   = 16'h9999;
    next_cycle();
    next_cycle();
    dm_we = 1'b0;
    @(negedge clk);
    check("abwr_stall", {15'd0, dm_stall}, 16'd0);
    next_cycle();
    next_cycle();
    do_access("lw20", 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b1, 16'h2020);
    idle();

    // Read+write together: error pulse, proceeds as a write, address aliases.
    do_access("rw_err", 1'b1, 1'b1, 16'hF005, 16'h5A5A, 1'b1, 16'h2020);
    idle();
    do_access("lw5", 1'b1, 1'b0, 16'h0005, 16'h0000, 1'b1, 16'h5A5A);
    idle();

    // Back-to-back reads.
    do_access("sw1", 1'b0, 1'b1, 16'h0001, 16'h1111, 1'b0, 16'h0);
    idle();
    do_access("sw2", 1'b0, 1'b1, 16'h0002, 16'h2222, 1'b0, 16'h0);
    idle();
    do_access("b2b_lw1", 1'b1, 1'b0, 16'h0001, 16'h0000, 1'b1, 16'h1111);
    do_access("b2b_lw2", 1'b1, 1'b0, 16'h0002, 16'h0000, 1'b1, 16'h2222);
    idle();

`ifdef DMEM_WBUF_EN
    begin
      int n_stall;
      n_stall = 0;
      dm_we   = 1'b1;
      dm_addr = 16'h0040;
      dm_in   = 16'h1234;
      @(negedge clk);
      check("wb_post_stall", {15'd0, dm_stall}, 16'd0);
      next_cycle();
      dm_we = 1'b0;
      dm_re = 1'b1;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (!dm_stall) break;
        n_stall++;
        next_cycle();
      end
      check("wb_lw_stalls", 16'(n_stall), 16'd6);
      check("wb_lw_data", dm_out, 16'h1234);
      next_cycle();
      idle();
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
